// File: rtl/tube_slave_pkg.sv
// Shared types and constants for the tube slave-side port controller.
package tube_slave_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_STROBE,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD,
        S_HOLDOFF
    } state_e;

    typedef enum logic {
        GRANT_RX = 1'b0,
        GRANT_TX = 1'b1
    } grant_e;

endpackage

// File: rtl/tube_slave_port_if.sv
// Bundle of tube latch flags/strobes plus the rx and tx valid/ready streams.
interface tube_slave_port_if;

    logic       slave_dor;
    logic       slave_dir;
    logic [7:0] slave_data_in;
    logic [7:0] slave_data_out;
    logic       slave_data_oe;
    logic       slave_rd_b;
    logic       slave_wr;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;

    modport slave (
        input  slave_dor, slave_dir, slave_data_in, rx_ready, tx_data, tx_valid,
        output slave_data_out, slave_data_oe, slave_rd_b, slave_wr,
               rx_data, rx_valid, tx_ready, busy
    );

    modport master (
        output slave_dor, slave_dir, slave_data_in, rx_ready, tx_data, tx_valid,
        input  slave_data_out, slave_data_oe, slave_rd_b, slave_wr,
               rx_data, rx_valid, tx_ready, busy
    );

endinterface

// File: rtl/tube_slave_timer.sv
// Loadable down-counter that parks at zero; done is high while the count is zero.
module tube_slave_timer
    import tube_slave_pkg::*;
(
    input  logic             clk,
    input  logic             reset_b,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/tube_slave_port.sv
// Slave-side controller for the host/slave byte-latch tube: arbitrates reads of the
// host-to-slave latch against writes to the slave-to-host latch and times the strobes.
module tube_slave_port
    import tube_slave_pkg::*;
#(
    parameter int RD_WAIT      = 2,
    parameter int WR_PULSE     = 2,
    parameter int FLAG_HOLDOFF = 2
) (
    input  logic             clk,
    input  logic             reset_b,
    tube_slave_port_if.slave bus
);

    localparam int CNT_MAX = (1 << CNT_W) - 1;

    if (RD_WAIT < 1 || RD_WAIT > CNT_MAX) begin : g_bad_rd_wait
        $error("tube_slave_port: RD_WAIT must be 1..15");
    end
    if (WR_PULSE < 1 || WR_PULSE > CNT_MAX) begin : g_bad_wr_pulse
        $error("tube_slave_port: WR_PULSE must be 1..15");
    end
    if (FLAG_HOLDOFF < 2 || FLAG_HOLDOFF > CNT_MAX) begin : g_bad_holdoff
        $error("tube_slave_port: FLAG_HOLDOFF must be 2..15");
    end

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] HO_LOAD = CNT_W'(FLAG_HOLDOFF - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    grant_e           r_last_grant;
    logic             r_rd_b;
    logic             r_wr;
    logic             r_oe;
    logic             r_rx_valid;
    logic [7:0]       r_data_out;
    logic [7:0]       r_rx_data;
    logic             w_rd_b_nxt;
    logic             w_wr_nxt;
    logic             w_oe_nxt;
    logic             w_rx_valid_nxt;
    logic [7:0]       w_data_out_nxt;
    logic [7:0]       w_rx_data_nxt;
    logic             w_in_idle;
    logic             w_rx_elig;
    logic             w_tx_elig;
    logic             w_grant_rx;
    logic             w_grant_tx;
    logic             w_timer_load;
    logic             w_timer_done;
    logic [CNT_W-1:0] w_timer_val;

    assign w_in_idle = (r_state == S_IDLE);
    assign w_rx_elig = bus.slave_dor & (~r_rx_valid | bus.rx_ready);
    assign w_tx_elig = bus.tx_valid & bus.slave_dir;

    // On a tie the side that did not win last time goes next.
    assign w_grant_rx = w_in_idle & w_rx_elig & (~w_tx_elig | (r_last_grant == GRANT_TX));
    assign w_grant_tx = w_in_idle & w_tx_elig & (~w_rx_elig | (r_last_grant == GRANT_RX));

    tube_slave_timer u_timer (
        .clk        (clk),
        .reset_b    (reset_b),
        .i_load     (w_timer_load),
        .i_load_val (w_timer_val),
        .o_done     (w_timer_done)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_rx) begin
                    w_state_nxt = S_RD_STROBE;
                end else if (w_grant_tx) begin
                    w_state_nxt = S_WR_SETUP;
                end
            end
            S_RD_STROBE: if (w_timer_done) w_state_nxt = S_HOLDOFF;
            S_WR_SETUP:  w_state_nxt = S_WR_PULSE;
            S_WR_PULSE:  if (w_timer_done) w_state_nxt = S_WR_HOLD;
            S_WR_HOLD:   w_state_nxt = S_HOLDOFF;
            S_HOLDOFF:   if (w_timer_done) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_timer_load   = 1'b0;
        w_timer_val    = '0;
        w_data_out_nxt = r_data_out;
        w_rx_data_nxt  = r_rx_data;
        w_rx_valid_nxt = r_rx_valid & ~bus.rx_ready;
        case (r_state)
            S_IDLE: begin
                if (w_grant_rx) begin
                    w_timer_load = 1'b1;
                    w_timer_val  = RD_LOAD;
                end
                if (w_grant_tx) begin
                    w_data_out_nxt = bus.tx_data;
                end
            end
            S_RD_STROBE: begin
                // The capture wins over a coincident pop, so the new byte stays valid.
                if (w_timer_done) begin
                    w_timer_load   = 1'b1;
                    w_timer_val    = HO_LOAD;
                    w_rx_data_nxt  = bus.slave_data_in;
                    w_rx_valid_nxt = 1'b1;
                end
            end
            S_WR_SETUP: begin
                w_timer_load = 1'b1;
                w_timer_val  = WR_LOAD;
            end
            S_WR_HOLD: begin
                w_timer_load = 1'b1;
                w_timer_val  = HO_LOAD;
            end
            default: ;
        endcase
    end

    assign w_rd_b_nxt = (w_state_nxt != S_RD_STROBE);
    assign w_wr_nxt   = (w_state_nxt == S_WR_PULSE);
    assign w_oe_nxt   = (w_state_nxt inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_rd_b       <= 1'b1;
            r_wr         <= 1'b0;
            r_oe         <= 1'b0;
            r_data_out   <= '0;
            r_rx_valid   <= 1'b0;
            r_rx_data    <= '0;
            r_last_grant <= GRANT_TX;
        end else begin
            r_rd_b     <= w_rd_b_nxt;
            r_wr       <= w_wr_nxt;
            r_oe       <= w_oe_nxt;
            r_data_out <= w_data_out_nxt;
            r_rx_valid <= w_rx_valid_nxt;
            r_rx_data  <= w_rx_data_nxt;
            if (w_grant_rx) begin
                r_last_grant <= GRANT_RX;
            end else if (w_grant_tx) begin
                r_last_grant <= GRANT_TX;
            end
        end
    end

    assign bus.slave_rd_b     = r_rd_b;
    assign bus.slave_wr       = r_wr;
    assign bus.slave_data_oe  = r_oe;
    assign bus.slave_data_out = r_data_out;
    assign bus.rx_valid       = r_rx_valid;
    assign bus.rx_data        = r_rx_data;
    assign bus.tx_ready       = w_grant_tx;
    assign bus.busy           = ~w_in_idle;

endmodule

// File: tb/tb_tube_slave_port.sv
// Self-checking bench for tube_slave_port: arbitration table, directed corner
// sequences, and a randomized run against a queue-based model of the two latches.
`timescale 1ns/1ps
module tb_tube_slave_port;

    localparam int RD_WAIT      = 2;
    localparam int WR_PULSE     = 2;
    localparam int FLAG_HOLDOFF = 2;
    localparam int RND_CYCLES   = 3000;
    localparam int DRAIN_CYCLES = 200;

    logic clk = 1'b0;
    logic reset_b = 1'b0;
    always #5 clk = ~clk;

    tube_slave_port_if bus();

    tube_slave_port #(
        .RD_WAIT      (RD_WAIT),
        .WR_PULSE     (WR_PULSE),
        .FLAG_HOLDOFF (FLAG_HOLDOFF)
    ) dut (
        .clk     (clk),
        .reset_b (reset_b),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic pre_fill;
        logic dor;
        logic dir;
        logic txv;
        logic rxr;
        logic exp_txr;
        logic exp_rd_b;
        logic exp_oe;
        logic exp_busy;
    } vec_t;

    vec_t vecs[10];

    int         n, oe_n, wr_n, wr_first, dat_bad, rd_n, rxv_first, overlap;
    int         grants[$];
    logic       prev_rd_b, prev_wr, tx_acc, gen;
    logic       h2s_full, h2s_clear, s2h_full;
    logic [7:0] h2s_byte;
    int         s2h_wait, rd_low, wr_high, rx_seen, tx_seen;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_tx[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.slave_dor     = 1'b0;
        bus.slave_dir     = 1'b0;
        bus.slave_data_in = 8'h00;
        bus.rx_ready      = 1'b0;
        bus.tx_data       = 8'h00;
        bus.tx_valid      = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset_b = 1'b0;
        step();
        step();
        reset_b = 1'b1;
    endtask

    task automatic wait_rx_valid(input string name, input int budget);
        int cnt = 0;
        while (!bus.rx_valid && cnt < budget) begin
            step();
            cnt++;
        end
        check(name, bus.rx_valid, 1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int cnt = 0;
        while (bus.busy && cnt < budget) begin
            step();
            cnt++;
        end
        check(name, bus.busy, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // pre_fill dor dir txv rxr | tx_ready rd_b oe busy (after one edge)
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset values while reset is held.
        clear_inputs();
        reset_b = 1'b0;
        step();
        check("rst_rd_b", bus.slave_rd_b, 1);
        check("rst_wr", bus.slave_wr, 0);
        check("rst_oe", bus.slave_data_oe, 0);
        check("rst_data_out", bus.slave_data_out, 8'h00);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 8'h00);
        check("rst_busy", bus.busy, 0);
        check("rst_tx_ready", bus.tx_ready, 0);

        // Arbitration table.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            if (vecs[i].pre_fill) begin
                bus.slave_dor     = 1'b1;
                bus.slave_data_in = 8'h5A;
                wait_rx_valid($sformatf("vec%0d_prefill_rx_valid", i), 10);
                bus.slave_dor = 1'b0;
                wait_idle($sformatf("vec%0d_prefill_idle", i), 10);
            end
            bus.slave_dor = vecs[i].dor;
            bus.slave_dir = vecs[i].dir;
            bus.tx_valid  = vecs[i].txv;
            bus.rx_ready  = vecs[i].rxr;
            bus.tx_data   = 8'hC3;
            #1;
            check($sformatf("vec%0d_tx_ready", i), bus.tx_ready, vecs[i].exp_txr);
            step();
            check($sformatf("vec%0d_rd_b", i), bus.slave_rd_b, vecs[i].exp_rd_b);
            check($sformatf("vec%0d_oe", i), bus.slave_data_oe, vecs[i].exp_oe);
            check($sformatf("vec%0d_busy", i), bus.busy, vecs[i].exp_busy);
        end

        // Single read with the consumer stalled.
        do_reset();
        bus.slave_dor     = 1'b1;
        bus.slave_data_in = 8'hA5;
        rd_n      = 0;
        rxv_first = -1;
        for (int k = 0; k < 24; k++) begin
            step();
            if (!bus.slave_rd_b) rd_n++;
            if (bus.rx_valid && rxv_first < 0) rxv_first = k;
        end
        check("rd_low_cycles", rd_n, RD_WAIT);
        check("rd_valid_latency", rxv_first, 2);
        check("rd_valid_held", bus.rx_valid, 1);
        check("rd_data", bus.rx_data, 8'hA5);

        // Single write.
        do_reset();
        bus.slave_dir = 1'b1;
        bus.tx_valid  = 1'b1;
        bus.tx_data   = 8'h3C;
        #1;
        check("wr_tx_ready", bus.tx_ready, 1);
        step();
        bus.tx_valid = 1'b0;
        #1;
        check("wr_tx_ready_once", bus.tx_ready, 0);
        oe_n     = 0;
        wr_n     = 0;
        wr_first = -1;
        dat_bad  = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.slave_data_oe) begin
                oe_n++;
                if (bus.slave_data_out !== 8'h3C) dat_bad++;
            end
            if (bus.slave_wr) begin
                wr_n++;
                if (wr_first < 0) wr_first = k;
            end
            step();
        end
        check("wr_oe_cycles", oe_n, 4);
        check("wr_pulse_cycles", wr_n, WR_PULSE);
        check("wr_rise_latency", wr_first, 1);
        check("wr_data_bad_cycles", dat_bad, 0);

        // Contention: grants must alternate starting with RX.
        do_reset();
        bus.slave_dor     = 1'b1;
        bus.slave_dir     = 1'b1;
        bus.tx_valid      = 1'b1;
        bus.rx_ready      = 1'b1;
        bus.slave_data_in = 8'h99;
        bus.tx_data       = 8'h66;
        grants.delete();
        prev_rd_b = 1'b1;
        overlap   = 0;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (bus.tx_ready) grants.push_back(1);
            step();
            if (prev_rd_b && !bus.slave_rd_b) grants.push_back(0);
            if (!bus.slave_rd_b && bus.slave_data_oe) overlap++;
            prev_rd_b = bus.slave_rd_b;
        end
        check("cont_grant_count", grants.size() >= 4, 1);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("cont_grant%0d", i), (i < grants.size()) ? grants[i] : 255, i % 2);
        end
        check("cont_rd_oe_overlap", overlap, 0);

        // Holdoff: a stale dor right after a read must not start another one.
        do_reset();
        bus.slave_dor     = 1'b1;
        bus.rx_ready      = 1'b1;
        bus.slave_data_in = 8'h11;
        wait_rx_valid("ho_first_read", 10);
        step();
        step();
        bus.slave_dor = 1'b0;
        rd_n = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (!bus.slave_rd_b) rd_n++;
        end
        check("ho_no_second_read", rd_n, 0);

        // Reset in the middle of the write pulse.
        do_reset();
        bus.slave_dir = 1'b1;
        bus.tx_valid  = 1'b1;
        bus.tx_data   = 8'h77;
        step();
        bus.tx_valid = 1'b0;
        n = 0;
        while (!bus.slave_wr && n < 10) begin
            step();
            n++;
        end
        check("rst_mid_reach_pulse", bus.slave_wr, 1);
        #2;
        reset_b = 1'b0;
        #1;
        check("rst_mid_wr", bus.slave_wr, 0);
        check("rst_mid_oe", bus.slave_data_oe, 0);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_rd_b", bus.slave_rd_b, 1);
        step();
        reset_b           = 1'b1;
        bus.slave_dir     = 1'b0;
        bus.slave_dor     = 1'b1;
        bus.slave_data_in = 8'h42;
        wait_rx_valid("rst_resume_rx_valid", 10);
        check("rst_resume_rx_data", bus.rx_data, 8'h42);

        // Randomized traffic against a model of the two latches.
        do_reset();
        h2s_full  = 1'b0;
        h2s_clear = 1'b0;
        h2s_byte  = 8'h00;
        s2h_full  = 1'b0;
        s2h_wait  = 0;
        prev_rd_b = 1'b1;
        prev_wr   = 1'b0;
        rd_low    = 0;
        wr_high   = 0;
        rx_seen   = 0;
        tx_seen   = 0;
        exp_rx.delete();
        exp_tx.delete();
        for (int cyc = 0; cyc < RND_CYCLES + DRAIN_CYCLES; cyc++) begin
            gen = (cyc < RND_CYCLES);
            // dor falls one cycle after the read strobe ends, inside the holdoff
            if (h2s_clear) begin
                h2s_full  = 1'b0;
                h2s_clear = 1'b0;
            end
            if (!bus.slave_rd_b) rd_low++;
            if (!prev_rd_b && bus.slave_rd_b) begin
                check("rnd_rd_len", rd_low, RD_WAIT);
                check("rnd_rd_when_full", h2s_full, 1);
                rd_low    = 0;
                h2s_clear = 1'b1;
            end
            if (bus.slave_wr) wr_high++;
            if (!prev_wr && bus.slave_wr) begin
                check("rnd_wr_when_empty", s2h_full, 0);
                check("rnd_wr_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check("rnd_wr_data", bus.slave_data_out, exp_tx.pop_front());
                s2h_full = 1'b1;
                s2h_wait = $urandom_range(0, 6);
                tx_seen++;
            end else if (s2h_full) begin
                if (s2h_wait == 0) s2h_full = 1'b0;
                else s2h_wait--;
            end
            if (prev_wr && !bus.slave_wr) begin
                check("rnd_wr_len", wr_high, WR_PULSE);
                wr_high = 0;
            end
            check("rnd_rd_oe_exclusive", !bus.slave_rd_b && bus.slave_data_oe, 0);
            check("rnd_wr_needs_oe", bus.slave_wr && !bus.slave_data_oe, 0);
            prev_rd_b = bus.slave_rd_b;
            prev_wr   = bus.slave_wr;

            if (gen && !h2s_full && $urandom_range(0, 2) == 0) begin
                h2s_byte = 8'($urandom);
                exp_rx.push_back(h2s_byte);
                h2s_full = 1'b1;
            end
            bus.slave_dor     = h2s_full;
            bus.slave_data_in = h2s_byte;
            bus.slave_dir     = !s2h_full;
            bus.rx_ready      = gen ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (gen && !bus.tx_valid && $urandom_range(0, 2) == 0) begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = 8'($urandom);
            end
            #1;
            if (bus.rx_valid && bus.rx_ready) begin
                check("rnd_rx_expected", exp_rx.size() != 0, 1);
                if (exp_rx.size() != 0) begin
                    check("rnd_rx_data", bus.rx_data, exp_rx.pop_front());
                    rx_seen++;
                end
            end
            tx_acc = bus.tx_valid && bus.tx_ready;
            if (tx_acc) exp_tx.push_back(bus.tx_data);
            step();
            if (tx_acc) bus.tx_valid = 1'b0;
        end
        check("rnd_rx_drained", exp_rx.size(), 0);
        check("rnd_tx_drained", exp_tx.size(), 0);
        check("rnd_rx_progress", rx_seen > 30, 1);
        check("rnd_tx_progress", tx_seen > 30, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tube_slave_port.md
Name: tube_slave_port

Overview:
- Slave-side controller for the host/slave byte-latch tube.
- Watches the slave flags: slave_dor means a host byte is waiting; slave_dir means the slave-to-host latch is empty.
- Generates the slave_rd_b and slave_wr strobes and sequences the shared 8-bit slave data bus.
- Exposes the transfers to slave-side logic as one valid/ready receive stream and one valid/ready transmit stream.

Parameters:
- RD_WAIT, 2: cycles slave_rd_b is held low before the bus is sampled (legal 1..15).
- WR_PULSE, 2: cycles slave_wr is held high (legal 1..15).
- FLAG_HOLDOFF, 2: cycles the flags are ignored after any strobe, covering the flag register lag (legal 2..15).

Ports:
- clk  in  1  system clock
- reset_b  in  1  asynchronous reset, active low
- slave_dor  in  1  host byte waiting in the host-to-slave latch
- slave_dir  in  1  slave-to-host latch empty, write permitted
- slave_data_in  in  8  slave data bus, read side
- slave_data_out  out  8  slave data bus, drive value
- slave_data_oe  out  1  slave data bus drive enable
- slave_rd_b  out  1  host-to-slave latch output enable, active low
- slave_wr  out  1  slave-to-host latch clock; the byte is captured on its rising edge
- rx_data  out  8  received byte
- rx_valid  out  1  rx_data holds an unconsumed byte
- rx_ready  in  1  consumer accepts rx_data
- tx_data  in  8  byte to send
- tx_valid  in  1  tx_data is valid
- tx_ready  out  1  tx_data accepted this cycle
- busy  out  1  state is not IDLE

Behaviour:
- Reset values (asynchronous): slave_rd_b=1, slave_wr=0, slave_data_oe=0, slave_data_out=0, rx_valid=0, rx_data=0, state=IDLE, last_grant=TX.
- All strobe and bus outputs are registered. tx_ready is combinational.
- rx_elig = slave_dor & (!rx_valid | rx_ready).
- tx_elig = tx_valid & slave_dir.
- Arbitration, in IDLE only:
  - If only one is eligible, it wins.
  - If both are eligible, the side opposite last_grant wins, so RX wins first after reset.
  - last_grant updates on every grant.
- States:
  - IDLE: on an RX grant go to RD_STROBE, with slave_rd_b<=0 and cnt<=RD_WAIT-1. On a TX grant assert tx_ready this cycle, then slave_data_out<=tx_data, slave_data_oe<=1, go to WR_SETUP.
  - RD_STROBE: slave_rd_b stays low for exactly RD_WAIT cycles. On the final edge: rx_data<=slave_data_in, rx_valid<=1, slave_rd_b<=1, go to HOLDOFF with cnt<=FLAG_HOLDOFF-1.
  - WR_SETUP: 1 cycle with data driven and slave_wr=0. Then slave_wr<=1 and go to WR_PULSE.
  - WR_PULSE: slave_wr is high for exactly WR_PULSE cycles. Then slave_wr<=0 and go to WR_HOLD.
  - WR_HOLD: 1 cycle with data still driven. Then slave_data_oe<=0 and go to HOLDOFF.
  - HOLDOFF: lasts FLAG_HOLDOFF cycles; slave_dor and slave_dir are ignored. Then go to IDLE.
- rx handshake:
  - rx_valid clears on any edge where rx_valid & rx_ready, including during a new read.
  - A capture edge coinciding with a pop leaves rx_valid=1 holding the new byte.
  - rx_data is stable while rx_valid=1 and rx_ready=0.
- Latency, defaults:
  - Read: IDLE grant edge to rx_valid rising is 2 edges. Back-to-back reads start every 1+RD_WAIT+FLAG_HOLDOFF = 5 cycles.
  - Write: tx_ready cycle to slave_wr rising is 2 edges. Back-to-back writes repeat every 1+1+WR_PULSE+1+FLAG_HOLDOFF = 7 cycles.
- Invariants:
  - slave_rd_b=0 and slave_data_oe=1 never occur together.
  - slave_wr=1 only while slave_data_oe=1.
- Flag drop mid-transfer: if a flag drops after a grant, the transfer still completes. Flags are only evaluated in IDLE.
- Reset mid-operation: outputs return to reset values immediately. A truncated slave_wr pulse or an aborted read is lost, with no retry.
- cnt is 4 bits and must never wrap; parameter legality is checked at elaboration.

Decomposition:
- Package tube_slave_pkg holds:
  - the state enum (IDLE, RD_STROBE, WR_SETUP, WR_PULSE, WR_HOLD, HOLDOFF);
  - CNT_W=4;
  - GRANT_RX/GRANT_TX constants.
- One sub-module, tube_slave_timer: a loadable 4-bit down-counter with a done flag. It is shared by RD_STROBE, WR_PULSE and HOLDOFF.

Test Plan:
- Single read:
  - Stimulus: slave_dor=1, slave_data_in=8'hA5, rx_ready=0.
  - Required: slave_rd_b low for exactly 2 cycles; rx_valid=1 with rx_data=8'hA5 two edges after the grant; no further read while rx_valid=1.
- Single write:
  - Stimulus: slave_dir=1, tx_valid=1, tx_data=8'h3C.
  - Required: one-cycle tx_ready; slave_data_oe high for 4 cycles with slave_data_out=8'h3C; slave_wr high exactly 2 cycles starting 2 edges after tx_ready.
- Contention:
  - Stimulus: slave_dor=1, slave_dir=1 and tx_valid=1 held, rx_ready=1.
  - Required: grants alternate RX, TX, RX, TX; rd_b low and oe are never concurrent.
- Backpressure:
  - Stimulus: rx_valid=1, rx_ready=0, slave_dor=1.
  - Required: no slave_rd_b strobe. Raising rx_ready for 1 cycle starts a read on that same cycle.
- Holdoff:
  - Stimulus: slave_dor stays 1 for 2 cycles after a read completes, then falls.
  - Required: no second read is started.
- Reset during WR_PULSE:
  - Stimulus: reset_b=0 while in WR_PULSE.
  - Required: slave_wr=0, slave_data_oe=0, busy=0 without waiting for a clock edge; after release, normal operation resumes.
